// File: rtl/irq_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: address width, state encoding and vector defaults.
// Optional feature macro used by this slice: INTC_RR_PRIO_EN (round-robin arbitration).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package irq_sequencer_pkg;

    localparam int IRQ_ADDR_WIDTH = `ADDR_WIDTH;

    localparam int                        IRQ_NUM_DEF           = 4;
    localparam int                        IRQ_DRAIN_DEF         = 3;
    localparam logic [IRQ_ADDR_WIDTH-1:0] IRQ_VECTOR_BASE_DEF   = IRQ_ADDR_WIDTH'(16'h0010);
    localparam int                        IRQ_VECTOR_STRIDE_DEF = 4;

    typedef enum logic [2:0] {
        IRQS_IDLE   = 3'd0,
        IRQS_DRAIN  = 3'd1,
        IRQS_VECTOR = 3'd2,
        IRQS_ISR    = 3'd3,
        IRQS_RETURN = 3'd4
    } irq_state_e;

    // Index width that stays at least one bit even for a single source
    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_sequencer_priority_encoder.sv
// Rotating priority encoder: finds the first set pending bit starting at start_i and wrapping around.
// With start_i tied to zero it degenerates to fixed lowest-index priority.
module irq_priority_encoder #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_IRQ-1:0] pending_i,
    input  logic [ID_W-1:0]    start_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    id_o
);

    function automatic int wrapIdx(input int base, input int offset);
        int t;
        t = base + offset;
        return (t >= NUM_IRQ) ? (t - NUM_IRQ) : t;
    endfunction

    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!valid_o && pending_i[wrapIdx(int'(start_i), i)]) begin
                valid_o = 1'b1;
                id_o    = ID_W'(wrapIdx(int'(start_i), i));
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: drains the pipeline by stalling fetch, redirects to a per-source vector,
// saves EPC and redirects back on reti. Define INTC_RR_PRIO_EN for round-robin arbitration.
module irq_sequencer
    import irq_sequencer_pkg::*;
#(
    parameter int                        NUM_IRQ       = IRQ_NUM_DEF,
    parameter int                        DRAIN_CYCLES  = IRQ_DRAIN_DEF,
    parameter logic [IRQ_ADDR_WIDTH-1:0] VECTOR_BASE   = IRQ_VECTOR_BASE_DEF,
    parameter int                        VECTOR_STRIDE = IRQ_VECTOR_STRIDE_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IRQ-1:0]        irq,
    input  logic                      mask_wr,
    input  logic [NUM_IRQ-1:0]        mask_data,
    input  logic [IRQ_ADDR_WIDTH-1:0] pc,
    input  logic                      pipe_flush,
    input  logic                      reti,
    output logic                      irq_stall,
    output logic                      irq_flush,
    output logic [IRQ_ADDR_WIDTH-1:0] irq_target,
    output logic [NUM_IRQ-1:0]        irq_ack,
    output logic                      in_isr,
    output logic [IRQ_ADDR_WIDTH-1:0] epc
);

    localparam int               ID_W       = idWidth(NUM_IRQ);
    localparam int               CNT_W      = idWidth(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DRAIN_CYCLES - 1);

    irq_state_e                state_q, state_d;
    logic [NUM_IRQ-1:0]        mask_q, mask_d;
    logic [ID_W-1:0]           id_q, id_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IRQ_ADDR_WIDTH-1:0] epc_q, epc_d;

    logic [NUM_IRQ-1:0]        pending;
    logic [ID_W-1:0]           startPtr;
    logic                      winnerValid;
    logic [ID_W-1:0]           winnerId;
    logic [IRQ_ADDR_WIDTH-1:0] vectorAddr;

    always_comb pending = irq & mask_q;

`ifdef INTC_RR_PRIO_EN
    localparam logic [ID_W-1:0] LAST_RESET = ID_W'(NUM_IRQ - 1);

    logic [ID_W-1:0] last_q, last_d;

    // Search begins just after the most recently serviced source
    always_comb begin
        last_d   = (state_q == IRQS_VECTOR) ? id_q : last_q;
        startPtr = (last_q == LAST_RESET) ? '0 : last_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) last_q <= LAST_RESET;
        else       last_q <= last_d;
    end
`else
    always_comb startPtr = '0;
`endif

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio (
        .pending_i (pending),
        .start_i   (startPtr),
        .valid_o   (winnerValid),
        .id_o      (winnerId)
    );

    always_comb vectorAddr = VECTOR_BASE
                           + IRQ_ADDR_WIDTH'(id_q) * IRQ_ADDR_WIDTH'(VECTOR_STRIDE);

    // A branch flush during drain is let through and restarts the drain count,
    // so EPC is only captured once the pipeline has truly emptied behind it.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        epc_d      = epc_q;
        mask_d     = mask_wr ? mask_data : mask_q;
        irq_stall  = 1'b0;
        irq_flush  = 1'b0;
        irq_target = '0;
        irq_ack    = '0;
        in_isr     = 1'b0;

        case (state_q)
            IRQS_IDLE: begin
                if (winnerValid && !pipe_flush) begin
                    id_d    = winnerId;
                    cnt_d   = CNT_RELOAD;
                    state_d = IRQS_DRAIN;
                end
            end
            IRQS_DRAIN: begin
                if (pipe_flush) begin
                    cnt_d = CNT_RELOAD;
                end else begin
                    irq_stall = 1'b1;
                    if (cnt_q == '0) begin
                        epc_d   = pc;
                        state_d = IRQS_VECTOR;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            IRQS_VECTOR: begin
                irq_flush  = 1'b1;
                irq_target = vectorAddr;
                irq_ack    = NUM_IRQ'(1) << id_q;
                in_isr     = 1'b1;
                state_d    = IRQS_ISR;
            end
            IRQS_ISR: begin
                in_isr = 1'b1;
                if (reti) state_d = IRQS_RETURN;
            end
            IRQS_RETURN: begin
                irq_flush  = 1'b1;
                irq_target = epc_q;
                state_d    = IRQS_IDLE;
            end
            default: state_d = IRQS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IRQS_IDLE;
            mask_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
        end
    end

    always_comb epc = epc_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: cycle-by-cycle vector table plus a hand-written entry/exit sequence.
// Expectations for the second vector choice follow INTC_RR_PRIO_EN when it is defined.
module tb_irq_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq;
    logic        mask_wr;
    logic [3:0]  mask_data;
    logic [15:0] pc;
    logic        pipe_flush;
    logic        reti;
    logic        irq_stall;
    logic        irq_flush;
    logic [15:0] irq_target;
    logic [3:0]  irq_ack;
    logic        in_isr;
    logic [15:0] epc;

    int checks = 0;
    int errors = 0;

`ifdef INTC_RR_PRIO_EN
    localparam logic [15:0] SECOND_TGT = 16'h001C;
    localparam logic [3:0]  SECOND_ACK = 4'b1000;
`else
    localparam logic [15:0] SECOND_TGT = 16'h0014;
    localparam logic [3:0]  SECOND_ACK = 4'b0010;
`endif

    typedef struct {
        logic        rst;
        logic [3:0]  irqV;
        logic        mwr;
        logic [3:0]  mdata;
        logic [15:0] pcV;
        logic        pf;
        logic        ret;
        logic        eStall;
        logic        eFlush;
        logic [15:0] eTarget;
        logic [3:0]  eAck;
        logic        eIsr;
        logic [15:0] eEpc;
    } vec_t;

    vec_t vecs[$];

    irq_sequencer #(
        .NUM_IRQ       (4),
        .DRAIN_CYCLES  (3),
        .VECTOR_BASE   (16'h0010),
        .VECTOR_STRIDE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .pc         (pc),
        .pipe_flush (pipe_flush),
        .reti       (reti),
        .irq_stall  (irq_stall),
        .irq_flush  (irq_flush),
        .irq_target (irq_target),
        .irq_ack    (irq_ack),
        .in_isr     (in_isr),
        .epc        (epc)
    );

    always #5 clk = ~clk;

    task automatic addVec(input logic rst, input logic [3:0] irqV, input logic mwr,
                          input logic [3:0] mdata, input logic [15:0] pcV, input logic pf,
                          input logic ret, input logic eStall, input logic eFlush,
                          input logic [15:0] eTarget, input logic [3:0] eAck,
                          input logic eIsr, input logic [15:0] eEpc);
        vec_t v;
        v.rst = rst; v.irqV = irqV; v.mwr = mwr; v.mdata = mdata; v.pcV = pcV;
        v.pf = pf; v.ret = ret; v.eStall = eStall; v.eFlush = eFlush;
        v.eTarget = eTarget; v.eAck = eAck; v.eIsr = eIsr; v.eEpc = eEpc;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        reset      = v.rst;
        irq        = v.irqV;
        mask_wr    = v.mwr;
        mask_data  = v.mdata;
        pc         = v.pcV;
        pipe_flush = v.pf;
        reti       = v.ret;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkVec(input int k, input vec_t v);
        checkOutput($sformatf("v%0d.stall", k),  32'(irq_stall),  32'(v.eStall));
        checkOutput($sformatf("v%0d.flush", k),  32'(irq_flush),  32'(v.eFlush));
        checkOutput($sformatf("v%0d.target", k), 32'(irq_target), 32'(v.eTarget));
        checkOutput($sformatf("v%0d.ack", k),    32'(irq_ack),    32'(v.eAck));
        checkOutput($sformatf("v%0d.isr", k),    32'(in_isr),     32'(v.eIsr));
        checkOutput($sformatf("v%0d.epc", k),    32'(epc),        32'(v.eEpc));
    endtask

    initial begin
        int stallCnt;
        int latency;
        logic seen;

        // rst irq mwr mdata pc pf reti | stall flush target ack isr epc
        addVec(1, 4'h0, 0, 4'h0, 16'h0020, 0, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0000); // 0 (unchecked)
        addVec(0, 4'h0, 1, 4'hF, 16'h0020, 0, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0000); // 1 reset state
        addVec(0, 4'h4, 0, 4'h0, 16'h0020, 0, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0000); // 2 request seen
        addVec(0, 4'h0, 0, 4'h0, 16'h0020, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0000); // 3 drain, irq dropped
        addVec(0, 4'h0, 0, 4'h0, 16'h0020, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0000);
        addVec(0, 4'h0, 0, 4'h0, 16'h0020, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0000);
        addVec(0, 4'h0, 0, 4'h0, 16'h0020, 0, 0,   0, 1, 16'h0018, 4'h4, 1, 16'h0020); // 6 vector id2
        addVec(0, 4'h1, 0, 4'h0, 16'h0020, 0, 0,   0, 0, 16'h0000, 4'h0, 1, 16'h0020); // 7 no nesting
        addVec(0, 4'h1, 0, 4'h0, 16'h0018, 0, 1,   0, 0, 16'h0000, 4'h0, 1, 16'h0020); // 8 reti
        addVec(0, 4'h1, 0, 4'h0, 16'h0018, 0, 0,   0, 1, 16'h0020, 4'h0, 0, 16'h0020); // 9 return
        addVec(0, 4'h1, 0, 4'h0, 16'h0018, 0, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0020); // 10 idle
        addVec(0, 4'h0, 0, 4'h0, 16'h0030, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0020); // 11 re-entry drain
        addVec(0, 4'h0, 0, 4'h0, 16'h0030, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0020);
        addVec(0, 4'h0, 0, 4'h0, 16'h0030, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0020);
        addVec(0, 4'h0, 0, 4'h0, 16'h0030, 0, 0,   0, 1, 16'h0010, 4'h1, 1, 16'h0030); // 14 vector id0
        addVec(0, 4'h0, 0, 4'h0, 16'h0030, 0, 1,   0, 0, 16'h0000, 4'h0, 1, 16'h0030);
        addVec(0, 4'hA, 0, 4'h0, 16'h0030, 0, 0,   0, 1, 16'h0030, 4'h0, 0, 16'h0030);
        addVec(0, 4'hA, 0, 4'h0, 16'h0030, 0, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0030); // 17 irq 1010
        addVec(0, 4'hA, 0, 4'h0, 16'h0044, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0030);
        addVec(0, 4'hA, 0, 4'h0, 16'h0044, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0030);
        addVec(0, 4'hA, 0, 4'h0, 16'h0044, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0030);
        addVec(0, 4'hA, 0, 4'h0, 16'h0044, 0, 0,   0, 1, 16'h0014, 4'h2, 1, 16'h0044); // 21 vector id1
        addVec(0, 4'hA, 0, 4'h0, 16'h0044, 0, 1,   0, 0, 16'h0000, 4'h0, 1, 16'h0044); // 22 reti (M)
        addVec(0, 4'hA, 0, 4'h0, 16'h0044, 0, 0,   0, 1, 16'h0044, 4'h0, 0, 16'h0044); // 23 M+1 return
        addVec(0, 4'hA, 0, 4'h0, 16'h0044, 0, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0044); // 24 M+2 idle
        addVec(0, 4'hA, 0, 4'h0, 16'h0050, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0044); // 25 M+3 drain
        addVec(0, 4'hA, 0, 4'h0, 16'h0050, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0044);
        addVec(0, 4'hA, 0, 4'h0, 16'h0050, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0044);
        addVec(0, 4'hA, 0, 4'h0, 16'h0050, 0, 0,   0, 1, SECOND_TGT, SECOND_ACK, 1, 16'h0050); // 28
        addVec(0, 4'h0, 0, 4'h0, 16'h0050, 0, 1,   0, 0, 16'h0000, 4'h0, 1, 16'h0050);
        addVec(0, 4'h0, 0, 4'h0, 16'h0050, 0, 0,   0, 1, 16'h0050, 4'h0, 0, 16'h0050);
        addVec(0, 4'h4, 0, 4'h0, 16'h0060, 0, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0050); // 31 request
        addVec(0, 4'h0, 0, 4'h0, 16'h0060, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0050);
        addVec(0, 4'h0, 0, 4'h0, 16'h0060, 1, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0050); // 33 branch in drain
        addVec(0, 4'h0, 0, 4'h0, 16'h0040, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0050);
        addVec(0, 4'h0, 0, 4'h0, 16'h0040, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0050);
        addVec(0, 4'h0, 0, 4'h0, 16'h0040, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0050);
        addVec(0, 4'h0, 0, 4'h0, 16'h0040, 0, 0,   0, 1, 16'h0018, 4'h4, 1, 16'h0040); // 37 vector, epc=branch
        addVec(0, 4'h0, 0, 4'h0, 16'h0040, 0, 1,   0, 0, 16'h0000, 4'h0, 1, 16'h0040);
        addVec(0, 4'h0, 0, 4'h0, 16'h0040, 0, 0,   0, 1, 16'h0040, 4'h0, 0, 16'h0040);
        addVec(0, 4'h4, 0, 4'h0, 16'h0040, 1, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0040); // 40 flush blocks entry
        addVec(0, 4'h0, 1, 4'h0, 16'h0040, 0, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0040); // 41 mask off
        addVec(0, 4'hF, 0, 4'h0, 16'h0040, 0, 1,   0, 0, 16'h0000, 4'h0, 0, 16'h0040); // 42 masked, reti idle
        addVec(0, 4'hF, 1, 4'hF, 16'h0040, 0, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0040);
        addVec(0, 4'h1, 0, 4'h0, 16'h0040, 0, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0040); // 44 request
        addVec(1, 4'h1, 0, 4'h0, 16'h0040, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0040); // 45 reset in drain
        addVec(0, 4'h1, 0, 4'h0, 16'h0040, 0, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0000); // 46 idle, epc cleared
        addVec(0, 4'h1, 0, 4'h0, 16'h0040, 0, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0000); // 47 mask cleared
        addVec(0, 4'h1, 1, 4'h1, 16'h0040, 0, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0000);
        addVec(0, 4'h1, 0, 4'h0, 16'h0040, 0, 0,   0, 0, 16'h0000, 4'h0, 0, 16'h0000); // 49 request
        addVec(0, 4'h0, 1, 4'h0, 16'h0040, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0000); // 50 mask change in drain
        addVec(0, 4'h0, 0, 4'h0, 16'h0070, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0000);
        addVec(0, 4'h0, 0, 4'h0, 16'h0070, 0, 0,   1, 0, 16'h0000, 4'h0, 0, 16'h0000);
        addVec(0, 4'h0, 0, 4'h0, 16'h0070, 0, 0,   0, 1, 16'h0010, 4'h1, 1, 16'h0070); // 53 still taken
        addVec(0, 4'h0, 0, 4'h0, 16'h0070, 0, 0,   0, 0, 16'h0000, 4'h0, 1, 16'h0070);

        foreach (vecs[k]) begin
            @(negedge clk);
            applyStimulus(vecs[k]);
            #2;
            if (k != 0) checkVec(k, vecs[k]);
        end

        // Hand-written entry: measure latency and verify stall/flush exclusivity each cycle
        @(negedge clk);
        applyStimulus('{1, 4'h0, 0, 4'h0, 16'h0088, 0, 0, 0, 0, 16'h0, 4'h0, 0, 16'h0});
        @(negedge clk);
        applyStimulus('{0, 4'h0, 1, 4'hF, 16'h0088, 0, 0, 0, 0, 16'h0, 4'h0, 0, 16'h0});
        @(negedge clk);
        mask_wr = 1'b0;
        irq     = 4'b0010;
        #2;
        checkOutput("seq.idleStall", 32'(irq_stall), 32'd0);
        stallCnt = 0;
        latency  = 0;
        seen     = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            irq = 4'b0000;
            #2;
            checkOutput($sformatf("seq.exclusive%0d", n), 32'(irq_stall & irq_flush), 32'd0);
            if (irq_stall) stallCnt++;
            if (irq_flush) begin
                seen    = 1'b1;
                latency = n;
            end
        end
        checkOutput("seq.entrySeen", 32'(seen), 32'd1);
        checkOutput("seq.latency", 32'(latency), 32'd4);
        checkOutput("seq.stallCnt", 32'(stallCnt), 32'd3);
        checkOutput("seq.target", 32'(irq_target), 32'h0014);
        checkOutput("seq.ack", 32'(irq_ack), 32'b0010);
        checkOutput("seq.epc", 32'(epc), 32'h0088);

        @(negedge clk);
        reti = 1'b1;
        #2;
        checkOutput("seq.inIsr", 32'(in_isr), 32'd1);
        @(negedge clk);
        reti = 1'b0;
        #2;
        checkOutput("seq.retFlush", 32'(irq_flush), 32'd1);
        checkOutput("seq.retTarget", 32'(irq_target), 32'h0088);
        checkOutput("seq.retIsr", 32'(in_isr), 32'd0);
        @(negedge clk);
        #2;
        checkOutput("seq.idleFlush", 32'(irq_flush), 32'd0);

        $display("[TB] vector table and sequences done");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
